// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - instruction memory port arbiter and byte-serial program loader
module imem_loader_ctrl #(
    parameter int IMEM_SIZE  = 128,
    parameter int LOAD_WORDS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] cpu_pc,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        im_we,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic [7:0]  word_cnt
);

    // An out-of-range word count is clamped into [1, IMEM_SIZE] so a bad
    // parameterisation can never write past the end of the memory.
    localparam int WORDS_CLAMPED = (LOAD_WORDS < 1) ? 1 :
                                   ((LOAD_WORDS > IMEM_SIZE) ? IMEM_SIZE : LOAD_WORDS);
    localparam logic [7:0] LAST_COUNT = 8'(WORDS_CLAMPED);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;
    logic [7:0]  word_cnt_inc;
    logic        byte_fire;
    logic [31:0] loader_addr;

    // A byte counts only while loading and not being aborted in the same cycle;
    // a byte presented alongside abort is dropped with the partial word.
    assign byte_fire    = (state == ST_LOAD) && byte_valid && !abort;
    assign word_cnt_inc = word_cnt + 8'd1;
    assign loader_addr  = {22'b0, word_cnt, 2'b00};

    // Next-state selection for the load sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                // start wins over a coincident abort while idle
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (byte_valid && (byte_cnt == 2'd3)) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // abort is not looked at here; the write always completes
                if (word_cnt_inc == LAST_COUNT) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE at once so the CPU regains the port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Byte packing (first byte lands in the MSB) and word counting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byte_cnt <= 2'd0;
            word_cnt <= 8'd0;
            asm_word <= 32'd0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                byte_cnt <= 2'd0;
                word_cnt <= 8'd0;
                asm_word <= 32'd0;
            end else if (byte_fire) begin
                asm_word <= {asm_word[23:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
            end else if (state == ST_WRITE) begin
                word_cnt <= word_cnt_inc;
            end
        end
    end

    // Port ownership and handshake outputs decoded from the current state.
    always_comb begin
        im_addr    = cpu_pc;
        im_wdata   = 32'd0;
        im_we      = 1'b0;
        byte_ready = 1'b0;
        cpu_stall  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                im_addr    = loader_addr;
                byte_ready = 1'b1;
                cpu_stall  = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                im_addr   = loader_addr;
                im_wdata  = asm_word;
                im_we     = 1'b1;
                cpu_stall = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                im_addr   = loader_addr;
                cpu_stall = 1'b1;
                busy      = 1'b1;
                done      = 1'b1;
            end
            default: begin
                im_addr = cpu_pc;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - self-checking bench for imem_loader_ctrl
module tb_imem_loader_ctrl;

    localparam int LW = 16;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] cpu_pc;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        im_we;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic [7:0]  word_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int done_cnt = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  mbytes[$];

    imem_loader_ctrl #(.IMEM_SIZE(128), .LOAD_WORDS(LW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_pc(cpu_pc), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
        .cpu_stall(cpu_stall), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // record every memory write and every done pulse
    always @(negedge CLK) begin
        if (im_we) begin
            log_addr.push_back(im_addr);
            log_data.push_back(im_wdata);
        end
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
        cycle++;
    endtask

    function automatic logic [31:0] model_word(input int k);
        return {mbytes[4*k], mbytes[4*k+1], mbytes[4*k+2], mbytes[4*k+3]};
    endfunction

    // offer one byte and hold it until the handshake completes
    task automatic feed_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 20) begin
            cyc();
            guard++;
        end
        if (!byte_ready) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        cyc();
        byte_valid = 1'b0;
        mbytes.push_back(b);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_log(input string tag, input int n);
        check({tag, "_count"}, 32'(log_addr.size()), 32'(n));
        for (int k = 0; k < n && k < log_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), log_addr[k], 32'(4 * k));
            check($sformatf("%s_data%0d", tag, k), log_data[k], model_word(k));
        end
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!done && guard < 30) begin
            cyc();
            guard++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic clear_model();
        log_addr.delete();
        log_data.delete();
        mbytes.delete();
        done_cnt = 0;
    endtask

    initial begin
        int c0;
        int pat[7];
        logic [31:0] pc;
        pat = '{1, 0, 0, 1, 1, 0, 1};

        RST = 1'b0; start = 1'b0; abort = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00; cpu_pc = 32'h0000_0010;

        // reset values and pass-through
        #1;
        check("rst_im_addr", im_addr, 32'h0000_0010);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_we", {31'd0, im_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
        cyc(); cyc();
        RST = 1'b1;
        cyc();
        check("idle_im_addr", im_addr, 32'h0000_0010);

        // first word packs big-endian, write one cycle after the 4th byte
        clear_model();
        start = 1'b1; cyc(); start = 1'b0;
        check("load_ready", {31'd0, byte_ready}, 32'd1);
        check("load_stall", {31'd0, cpu_stall}, 32'd1);
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_addr", im_addr, 32'd0);
        feed_byte(8'h20); feed_byte(8'h01); feed_byte(8'h00); feed_byte(8'h05);
        check("w0_we", {31'd0, im_we}, 32'd1);
        check("w0_addr", im_addr, 32'd0);
        check("w0_data", im_wdata, 32'h2001_0005);
        check("w0_ready", {31'd0, byte_ready}, 32'd0);
        cyc();
        check("w0_word_cnt", {24'd0, word_cnt}, 32'd1);
        check("w0_next_addr", im_addr, 32'd4);
        abort = 1'b1; cyc(); abort = 1'b0;
        check("abort1_busy", {31'd0, busy}, 32'd0);
        check("abort1_word_cnt", {24'd0, word_cnt}, 32'd1);
        check("abort1_done", 32'(done_cnt), 32'd0);

        // full back-to-back load of bytes 0..63 with cycle-exact completion
        clear_model();
        start = 1'b1; cyc(); start = 1'b0;
        c0 = cycle;
        for (int i = 0; i < 4 * LW; i++) feed_byte(8'(i));
        wait_done("full");
        check("full_latency", 32'(cycle - c0), 32'(5 * LW));
        check("full_done_stall", {31'd0, cpu_stall}, 32'd1);
        check("full_done_we", {31'd0, im_we}, 32'd0);
        cyc();
        check("full_after_stall", {31'd0, cpu_stall}, 32'd0);
        check("full_after_busy", {31'd0, busy}, 32'd0);
        check("full_after_addr", im_addr, cpu_pc);
        check("full_word_cnt", {24'd0, word_cnt}, 32'(LW));
        check("full_done_count", 32'(done_cnt), 32'd1);
        check_log("full", LW);

        // gapped valid pattern, then start ignored mid-load, then abort
        clear_model();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            byte_valid = pat[i][0];
            byte_data  = 8'($urandom);
            if (pat[i] == 1) mbytes.push_back(byte_data);
            cyc();
            if (i < 6) check($sformatf("gap_we_%0d", i), {31'd0, im_we}, 32'd0);
        end
        byte_valid = 1'b0;
        check("gap_we", {31'd0, im_we}, 32'd1);
        check("gap_data", im_wdata, model_word(0));
        feed_byte(8'($urandom)); feed_byte(8'($urandom));
        start = 1'b1; cyc(); start = 1'b0;
        check("busy_start_word_cnt", {24'd0, word_cnt}, 32'd1);
        check("busy_start_ready", {31'd0, byte_ready}, 32'd1);
        feed_byte(8'($urandom)); feed_byte(8'($urandom));
        check("w1_we", {31'd0, im_we}, 32'd1);
        feed_byte(8'($urandom)); feed_byte(8'($urandom));
        abort = 1'b1; byte_valid = 1'b1; byte_data = 8'($urandom);
        cyc();
        abort = 1'b0; byte_valid = 1'b0;
        check("abort2_busy", {31'd0, busy}, 32'd0);
        check("abort2_word_cnt", {24'd0, word_cnt}, 32'd2);
        idle_gap(4);
        check("abort2_done", 32'(done_cnt), 32'd0);
        check_log("abort2", 2);

        // randomized loads with random byte gaps; first one also has abort with start
        for (int r = 0; r < 2; r++) begin
            clear_model();
            start = 1'b1; abort = (r == 0);
            cyc();
            start = 1'b0; abort = 1'b0;
            check($sformatf("rnd%0d_busy", r), {31'd0, busy}, 32'd1);
            for (int i = 0; i < 4 * LW; i++) begin
                idle_gap($urandom_range(0, 2));
                feed_byte(8'($urandom));
            end
            wait_done($sformatf("rnd%0d", r));
            cyc();
            pc = $urandom & 32'hFFFF_FFFC;
            cpu_pc = pc;
            #1;
            check($sformatf("rnd%0d_pc", r), im_addr, pc);
            check($sformatf("rnd%0d_done_count", r), 32'(done_cnt), 32'd1);
            check($sformatf("rnd%0d_word_cnt", r), {24'd0, word_cnt}, 32'(LW));
            check_log($sformatf("rnd%0d", r), LW);
            cyc();
        end

        // asynchronous reset during the third word
        clear_model();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 10; i++) feed_byte(8'($urandom));
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, cpu_stall}, 32'd0);
        check("arst_ready", {31'd0, byte_ready}, 32'd0);
        check("arst_we", {31'd0, im_we}, 32'd0);
        check("arst_word_cnt", {24'd0, word_cnt}, 32'd0);
        check("arst_wdata", im_wdata, 32'd0);
        check("arst_addr", im_addr, cpu_pc);
        byte_valid = 1'b1;
        cyc(); cyc();
        RST = 1'b1;
        idle_gap(6);
        byte_valid = 1'b0;
        check("arst_busy_after", {31'd0, busy}, 32'd0);
        check("arst_log", 32'(log_addr.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
